// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage and its register file.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package wb_regfile_pkg;

  // Default widths.
  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int NUM_REGS_DEF = 32;

  // Control encodings.
  localparam logic RstEnable    = 1'b1;
  localparam logic RstDisable   = 1'b0;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic ReadEnable   = 1'b1;
  localparam logic ReadDisable  = 1'b0;

  // Value constants.
  localparam logic [DATA_W_DEF-1:0] ZeroWord   = '0;
  localparam logic [ADDR_W_DEF-1:0] NOPRegAddr = '0;

endpackage

// File: rtl/wb_regfile_array.sv
// General-purpose register file: one write port, two combinational read ports.
// Latency: write lands on the next rising edge; reads are combinational.
// Backpressure: none; the write port is the bypass source for reads.
//
// Ports:
//   clk_i, rst_i                 clock, async active-high reset
//   we_i, waddr_i, wdata_i       write port (also the bypass entry)
//   re1_i, raddr1_i, rdata1_o    read port 1
//   re2_i, raddr2_i, rdata2_o    read port 2
module regfile_array
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i == WriteEnable && waddr_i != ADDR_W'(NOPRegAddr)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read priority: reset, disabled port, r0, bypass of the pending write, storage.
  // The bypass makes the pending write visible one edge before it is stored.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic              rst,
    input logic              re,
    input logic [ADDR_W-1:0] ra,
    input logic              we,
    input logic [ADDR_W-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] r;
    r = DATA_W'(ZeroWord);
    if (rst == RstEnable) begin
      r = DATA_W'(ZeroWord);
    end else if (re == ReadDisable) begin
      r = DATA_W'(ZeroWord);
    end else if (ra == ADDR_W'(NOPRegAddr)) begin
      r = DATA_W'(ZeroWord);
    end else if (we == WriteEnable && ra == wa) begin
      r = wd;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  always_comb begin
    rdata1_o = read_mux(rst_i, re1_i, raddr1_i, we_i, waddr_i, wdata_i, regs_q[raddr1_i]);
    rdata2_o = read_mux(rst_i, re2_i, raddr2_i, we_i, waddr_i, wdata_i, regs_q[raddr2_i]);
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: MEM/WB latch with stall/flush, committing into the register file.
// Latency: MEM input captured on edge 1, committed to storage on edge 2; reads are combinational with bypass.
// Backpressure: stall_i holds the latch (recommit is idempotent); flush_i replaces it with a NOP.
//
// Ports:
//   clk, resetn                         clock, async active-high reset (1 = asserted)
//   wdata_i, wd_i, wreg_i               write-back triple from the MEM stage
//   stall_i, flush_i                    latch hold / squash (flush wins)
//   re1_i, raddr1_i, rdata1_o           decode read port 1
//   re2_i, raddr2_i, rdata2_o           decode read port 2
//   wb_wdata_o, wb_wd_o, wb_wreg_o      latched triple, exported for forwarding
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [DATA_W-1:0] wb_wdata_o,
  output logic [ADDR_W-1:0] wb_wd_o,
  output logic              wb_wreg_o
);

  logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
  logic [ADDR_W-1:0] wb_wd_q,    wb_wd_d;
  logic              wb_wreg_q,  wb_wreg_d;

  // Flush beats stall beats capture.
  always_comb begin
    wb_wdata_d = wb_wdata_q;
    wb_wd_d    = wb_wd_q;
    wb_wreg_d  = wb_wreg_q;
    if (flush_i) begin
      wb_wdata_d = DATA_W'(ZeroWord);
      wb_wd_d    = ADDR_W'(NOPRegAddr);
      wb_wreg_d  = WriteDisable;
    end else if (!stall_i) begin
      wb_wdata_d = wdata_i;
      wb_wd_d    = wd_i;
      wb_wreg_d  = wreg_i;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      wb_wdata_q <= DATA_W'(ZeroWord);
      wb_wd_q    <= ADDR_W'(NOPRegAddr);
      wb_wreg_q  <= WriteDisable;
    end else begin
      wb_wdata_q <= wb_wdata_d;
      wb_wd_q    <= wb_wd_d;
      wb_wreg_q  <= wb_wreg_d;
    end
  end

  assign wb_wdata_o = wb_wdata_q;
  assign wb_wd_o    = wb_wd_q;
  assign wb_wreg_o  = wb_wreg_q;

  // The array's write port is fed from the pre-edge latch, so a flush on the
  // same edge still lets the outgoing entry commit.
  regfile_array #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile_array (
    .clk_i   (clk),
    .rst_i   (resetn),
    .we_i    (wb_wreg_q),
    .waddr_i (wb_wd_q),
    .wdata_i (wb_wdata_q),
    .re1_i   (re1_i),
    .raddr1_i(raddr1_i),
    .rdata1_o(rdata1_o),
    .re2_i   (re2_i),
    .raddr2_i(raddr2_i),
    .rdata2_o(rdata2_o)
  );

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic [DW-1:0] wdata_i;
  logic [AW-1:0] wd_i;
  logic          wreg_i, stall_i, flush_i;
  logic          re1_i, re2_i;
  logic [AW-1:0] raddr1_i, raddr2_i;
  logic [DW-1:0] rdata1_o, rdata2_o, wb_wdata_o;
  logic [AW-1:0] wb_wd_o;
  logic          wb_wreg_o;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wdata_i   (wdata_i),
    .wd_i      (wd_i),
    .wreg_i    (wreg_i),
    .stall_i   (stall_i),
    .flush_i   (flush_i),
    .re1_i     (re1_i),
    .raddr1_i  (raddr1_i),
    .rdata1_o  (rdata1_o),
    .re2_i     (re2_i),
    .raddr2_i  (raddr2_i),
    .rdata2_o  (rdata2_o),
    .wb_wdata_o(wb_wdata_o),
    .wb_wd_o   (wb_wd_o),
    .wb_wreg_o (wb_wreg_o)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register values plus one pending write.
  logic [31:0] m_regs [NR];
  logic [31:0] p_data;
  logic [4:0]  p_wd;
  logic        p_we;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] wdata;
    logic [4:0]  wd;
    logic        wreg;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  event mon_ev;

  task automatic model_clear();
    for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
    p_data = 32'h0;
    p_wd   = 5'h0;
    p_we   = 1'b0;
  endtask

  // Called at each rising edge, before the bench changes any input.
  task automatic model_edge();
    if (resetn) begin
      model_clear();
    end else begin
      if (p_we && p_wd != 5'd0) m_regs[p_wd] = p_data;
      if (flush_i) begin
        p_data = 32'h0; p_wd = 5'h0; p_we = 1'b0;
      end else if (!stall_i) begin
        p_data = wdata_i; p_wd = wd_i; p_we = wreg_i;
      end
    end
  endtask

  // Value the decode stage should see: the newest write to that register,
  // whether already stored or still pending.
  function automatic logic [31:0] arch_read(input logic re, input logic [4:0] ra);
    if (resetn || !re || ra == 5'd0) return 32'h0;
    if (p_we && p_wd == ra) return p_data;
    return m_regs[ra];
  endfunction

  task automatic push(input string name);
    exp_t e;
    e.name  = name;
    e.r1    = arch_read(re1_i, raddr1_i);
    e.r2    = arch_read(re2_i, raddr2_i);
    e.wdata = resetn ? 32'h0 : p_data;
    e.wd    = resetn ? 5'h0 : p_wd;
    e.wreg  = resetn ? 1'b0 : p_we;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic [31:0] wdat, input logic [4:0] wd,
                     input logic we, input logic st, input logic fl,
                     input logic r1e, input logic [4:0] r1a,
                     input logic r2e, input logic [4:0] r2a, input string name);
    @(posedge clk);
    model_edge();
    #1;
    resetn = rst; wdata_i = wdat; wd_i = wd; wreg_i = we;
    stall_i = st; flush_i = fl;
    re1_i = r1e; raddr1_i = r1a; re2_i = r2e; raddr2_i = r2a;
    push(name);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against every pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      #1;
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk({e.name, "/rdata1"},   rdata1_o,           e.r1);
        chk({e.name, "/rdata2"},   rdata2_o,           e.r2);
        chk({e.name, "/wb_wdata"}, wb_wdata_o,         e.wdata);
        chk({e.name, "/wb_wd"},    32'(wb_wd_o),       32'(e.wd));
        chk({e.name, "/wb_wreg"},  32'(wb_wreg_o),     32'(e.wreg));
      end
    end
  end

  initial begin
    logic [4:0] a1, a2, aw;
    resetn = 1'b1; wdata_i = 32'hDEADBEEF; wd_i = 5'd5; wreg_i = 1'b1;
    stall_i = 1'b0; flush_i = 1'b0;
    re1_i = 1'b1; raddr1_i = 5'd5; re2_i = 1'b1; raddr2_i = 5'd5;
    model_clear();

    // Reset held with live write inputs.
    repeat (3) cyc(1, 32'hDEADBEEF, 5, 1, 0, 0, 1, 5, 1, 5, "rst_hold");
    cyc(0, 0, 0, 0, 0, 0, 1, 5, 1, 5, "rst_release");
    cyc(0, 0, 0, 0, 0, 0, 1, 5, 1, 5, "r5_after_rst");

    // Basic write: bypass before commit, storage after.
    cyc(0, 32'h12345678, 3, 1, 0, 0, 1, 3, 1, 3, "wr_issue");
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 1, 3, "wr_bypass");
    cyc(0, 0, 0, 0, 0, 0, 1, 3, 1, 3, "wr_commit");

    // r0 protection.
    cyc(0, 32'hFFFFFFFF, 0, 1, 0, 0, 1, 0, 1, 0, "r0_issue");
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "r0_latched");
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "r0_after");

    // Stall then stall+flush.
    cyc(0, 32'h00000066, 6, 1, 0, 0, 1, 7, 1, 6, "sf_load");
    cyc(0, 32'hA5A5A5A5, 7, 1, 1, 0, 1, 7, 1, 6, "sf_stall");
    cyc(0, 32'hA5A5A5A5, 7, 1, 1, 1, 1, 7, 1, 6, "sf_held");
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 1, 6, "sf_flushed");
    cyc(0, 0, 0, 0, 0, 0, 1, 7, 1, 6, "sf_after");

    // Dual read and enables.
    cyc(0, 32'h11, 1, 1, 0, 0, 0, 0, 0, 0, "dr_w1");
    cyc(0, 32'h22, 2, 1, 0, 0, 0, 0, 0, 0, "dr_w2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "dr_nop");
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 2, "dr_re2_off");
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, "dr_same_addr");
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 2, "dr_both");

    // Async reset between edges after r4 is committed.
    cyc(0, 32'h44, 4, 1, 0, 0, 1, 4, 1, 4, "ar_w4");
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 1, 4, "ar_bypass");
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 1, 4, "ar_committed");
    @(negedge clk);
    #2;
    resetn = 1'b1;
    model_clear();
    push("ar_async");
    ->mon_ev;
    cyc(1, 0, 0, 0, 0, 0, 1, 4, 1, 4, "ar_held");
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 1, 4, "ar_release");
    cyc(0, 0, 0, 0, 0, 0, 1, 4, 1, 4, "ar_r4_zero");

    // Randomized traffic with stalls, flushes and occasional resets.
    for (int n = 0; n < 400; n++) begin
      aw = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      a2 = ($urandom_range(0, 1) == 0) ? a1 : 5'($urandom_range(0, 7));
      cyc(($urandom_range(0, 99) == 0), $urandom, aw, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 3) != 0), a1, ($urandom_range(0, 3) != 0), a2, "rand");
    end

    repeat (2) @(negedge clk);
    #2;
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    #2;
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM-stage interface: consumes the MEM stage's (wdata, wd, wreg) triple.
- Holds it in a MEM/WB pipeline latch with stall/flush control, then commits it to a 32x32 general-purpose register file.
- Provides two combinational read ports with write-back bypass, used by the decode stage.
- The latched write-back triple is also exported for downstream forwarding logic.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired to zero

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- resetn  input  1  asynchronous, active-high reset (1 = reset asserted)
- wdata_i  input  DATA_W  write-back data from the MEM stage
- wd_i  input  ADDR_W  destination register address from the MEM stage
- wreg_i  input  1  write enable from the MEM stage
- stall_i  input  1  hold the MEM/WB latch this cycle
- flush_i  input  1  squash the MEM/WB latch this cycle
- re1_i  input  1  read-port-1 enable
- raddr1_i  input  ADDR_W  read-port-1 address
- rdata1_o  output  DATA_W  read-port-1 data
- re2_i  input  1  read-port-2 enable
- raddr2_i  input  ADDR_W  read-port-2 address
- rdata2_o  output  DATA_W  read-port-2 data
- wb_wdata_o  output  DATA_W  latched write-back data
- wb_wd_o  output  ADDR_W  latched destination address
- wb_wreg_o  output  1  latched write enable

Behaviour:
- Reset (resetn=1, asynchronous assert):
  - Latch cleared: wb_wd_o=0, wb_wreg_o=0, wb_wdata_o=0.
  - All NUM_REGS registers cleared to 0.
  - rdata1_o=rdata2_o=0 while reset is asserted.
- Reset deassert: first capture occurs on the first rising edge after resetn falls.
- Latch update, each rising edge, priority flush > stall > capture:
  - flush_i=1: latch <= (0, 0, 0), i.e. a NOP.
  - stall_i=1 (no flush): latch holds its value.
  - Otherwise: latch <= (wdata_i, wd_i, wreg_i).
- Commit, each rising edge:
  - If wb_wreg_o=1 and wb_wd_o!=0, regs[wb_wd_o] <= wb_wdata_o.
  - Commit uses the pre-edge latch contents, so MEM->regfile latency is 2 edges (capture, then commit).
  - A held (stalled) latch recommits the same value each edge; this is idempotent.
  - Flush does not cancel the commit of the entry being replaced on that same edge.
- Writes with wb_wd_o=0 are discarded; regs[0] always reads 0.
- Read ports (combinational, identical for port 1 and port 2), priority:
  1. resetn=1 -> 0
  2. re=0 -> 0
  3. raddr=0 -> 0
  4. wb_wreg_o=1 and raddr==wb_wd_o -> wb_wdata_o (bypass of the uncommitted entry)
  5. otherwise -> regs[raddr]
- No bypass from wd_i/wdata_i; MEM-stage forwarding is handled in decode.
- Both ports may read the same address in the same cycle; both receive identical data.
- Reset asserted mid-stall or mid-flush: reset wins immediately; all stall/flush state is irrelevant afterwards.

Decomposition:
- Shared package/define file:
  - RstEnable/RstDisable, WriteEnable/WriteDisable, ZeroWord, NOPRegAddr
  - ReadEnable/ReadDisable
  - DATA_W/ADDR_W defaults
- Sub-module regfile_array:
  - register storage, async reset, single write port, two combinational read ports with the r0/enable/bypass priority
- wb_regfile contains the MEM/WB latch and instantiates regfile_array.

Test Plan:
- Reset: hold resetn=1 with wd_i=5, wreg_i=1, wdata_i=32'hDEADBEEF, clock 3 edges -> wb_* all 0; reading r5 returns 0 after release.
- Basic write: wd_i=3, wreg_i=1, wdata_i=32'h12345678 at edge 1 -> wb_wd_o=3 after edge 1; reading r3 returns 32'h12345678 (via bypass) before edge 2 and (from array) after edge 2 with inputs set to NOP.
- r0 protection: wd_i=0, wreg_i=1, wdata_i=32'hFFFFFFFF -> rdata of r0 stays 0 on both ports at all times.
- Stall/flush:
  - stall_i=1 with new inputs (wd_i=7, wdata_i=32'hA5A5A5A5) -> wb_* unchanged.
  - Next edge with stall_i=1 and flush_i=1 -> wb_wreg_o=0, wb_wd_o=0; r7 never written.
- Dual read and enables:
  - r1=32'h11, r2=32'h22 committed; raddr1=1, raddr2=2, re1=1, re2=0 -> rdata1=32'h11, rdata2=0.
  - Set raddr2=1, re2=1 -> rdata2=32'h11.
- Async reset mid-operation: assert resetn between clock edges after r4=32'h44 is committed -> rdata for r4 drops to 0 without a clock edge; after release r4 reads 0.
